// File: rtl/ready_draw.sv
// Ready-gated draw latch: once every player's READY has been held long enough,
// captures the free-running draw source. Define READY_DRAW_LFSR_EN for an LFSR source.
module ready_draw #(
  parameter int PLAYERS  = 2,
  parameter int NUM_W    = 4,
  parameter int NUM_MIN  = 0,
  parameter int NUM_MAX  = 9,
  parameter int TICK_DIV = 5_000_000,
  parameter int HOLD_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PLAYERS-1:0] READY,
  input  logic               ACK,
  output logic [NUM_W-1:0]   NUM,
  output logic               OK,
  output logic               DRAW_P,
  output logic               ALL_READY
);

  localparam int HOLD_W = $clog2(HOLD_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ARMED, DRAW, DONE} state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               lock_q, lock_d;
  logic [NUM_W-1:0]   num_d;
  logic               ok_d, draw_p_d;
  logic [NUM_W-1:0]   sec;

`ifdef READY_DRAW_LFSR_EN
  localparam int RANGE  = NUM_MAX - NUM_MIN + 1;
  localparam int FOLD_N = ((2 ** (NUM_W + 1)) + RANGE - 1) / RANGE;
  localparam logic [NUM_W:0] RANGE_V = (NUM_W + 1)'(RANGE);

  logic [15:0]  lfsr;
  logic [NUM_W:0] fold;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
  always_ff @(posedge CLK) begin
    if (RST) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    fold = lfsr[NUM_W:0];
    for (int i = 0; i < FOLD_N; i++) begin
      if (fold >= RANGE_V) fold = fold - RANGE_V;
    end
    sec = NUM_W'(NUM_MIN) + fold[NUM_W-1:0];
  end
`else
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // Tick divider and wrapped draw counter run regardless of game state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      sec <= NUM_W'(NUM_MIN);
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) sec <= (sec == NUM_W'(NUM_MAX)) ? NUM_W'(NUM_MIN) : sec + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALL_READY <= 1'b0;
      state_q   <= IDLE;
      hold_q    <= '0;
      lock_q    <= 1'b0;
      NUM       <= '0;
      OK        <= 1'b0;
      DRAW_P    <= 1'b0;
    end else begin
      ALL_READY <= &READY;
      state_q   <= state_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      NUM       <= num_d;
      OK        <= ok_d;
      DRAW_P    <= draw_p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lock_d   = lock_q;
    num_d    = NUM;
    ok_d     = OK;
    draw_p_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ALL_READY && !lock_q) begin
          state_d = ARMED;
          hold_d  = '0;
        end
      end
      ARMED: begin
        if (!ALL_READY) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          state_d = DRAW;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DRAW: begin
        num_d    = sec;
        ok_d     = 1'b1;
        draw_p_d = 1'b1;
        lock_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (ACK) begin
          state_d = IDLE;
          ok_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A release always unlocks, so a fresh press is needed for the next draw.
    if (!ALL_READY) lock_d = 1'b0;
  end

endmodule
